// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - byte-stream loader and CRC-8 rotate-verify for a configuration flip-flop chain
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       prog_clk,
    input  logic       prog_reset,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       ccff_shift_en,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic [7:0] crc_value
);

    localparam int              NBYTES   = (CHAIN_LEN + 7) / 8;
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] NBYTES_C = CNT_W'(NBYTES);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;     // bits shifted in LOAD, rotate cycles in VERIFY
    logic [CNT_W-1:0] bytes_left;  // bytes still to accept; the last one may be partial
    logic [7:0]       buf_data;
    logic [3:0]       buf_cnt;
    logic [7:0]       crc_load;
    logic [7:0]       crc_vfy;
    logic [7:0]       crc_vfy_nxt;
    logic             shift_load;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // The final verify CRC must include the bit arriving on the FINISH-entry edge
    assign crc_vfy_nxt = crc8_step(crc_vfy, ccff_tail);

    // Next-state, handshake and chain drive; reset kills shifting in its own cycle
    always_comb begin
        state_nxt     = state;
        shift_load    = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        s_ready       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                busy          = 1'b1;
                shift_load    = (buf_cnt != 4'd0) && (bit_cnt < LEN_C);
                ccff_shift_en = shift_load;
                ccff_head     = buf_data[0];
                // Refill while the last buffered bit leaves so bytes flow without a bubble
                s_ready       = (bytes_left != '0) &&
                                ((buf_cnt == 4'd0) || ((buf_cnt == 4'd1) && shift_load));
                if (shift_load && (bit_cnt == LAST_C)) state_nxt = VERIFY;
            end
            VERIFY: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                if (bit_cnt == LAST_C) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (prog_reset) begin
            ccff_shift_en = 1'b0;
            s_ready       = 1'b0;
        end
    end

    // State, byte buffer, counters and both CRC accumulators
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bytes_left <= '0;
            buf_data   <= 8'h00;
            buf_cnt    <= 4'd0;
            crc_load   <= 8'h00;
            crc_vfy    <= 8'h00;
            crc_err    <= 1'b0;
            crc_value  <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt    <= '0;
                        bytes_left <= NBYTES_C;
                        buf_data   <= 8'h00;
                        buf_cnt    <= 4'd0;
                        crc_load   <= 8'h00;
                        crc_vfy    <= 8'h00;
                        crc_err    <= 1'b0;
                        crc_value  <= 8'h00;
                    end
                end
                LOAD: begin
                    if (s_ready && s_valid) begin
                        buf_data   <= s_data;
                        buf_cnt    <= 4'd8;
                        bytes_left <= bytes_left - 1'b1;
                    end else if (shift_load) begin
                        buf_data <= {1'b0, buf_data[7:1]};
                        buf_cnt  <= buf_cnt - 1'b1;
                    end
                    if (shift_load) begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        crc_load <= crc8_step(crc_load, buf_data[0]);
                    end
                    // Drop unused upper bits of a partial last byte and reuse bit_cnt for the rotate
                    if (state_nxt == VERIFY) begin
                        bit_cnt  <= '0;
                        buf_data <= 8'h00;
                        buf_cnt  <= 4'd0;
                    end
                end
                VERIFY: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    crc_vfy <= crc_vfy_nxt;
                    if (state_nxt == FINISH) begin
                        crc_err   <= (crc_vfy_nxt != crc_load);
                        crc_value <= crc_load;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench for ccff_chain_loader with behavioural chains
module tb_ccff_chain_loader;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       start_a, start_b;
    logic [7:0] s_data;
    logic       s_valid;

    logic       s_ready_a, head_a, tail_a, shift_a, busy_a, done_a, err_a;
    logic [7:0] crc_a;
    logic       s_ready_b, head_b, tail_b, shift_b, busy_b, done_b, err_b;
    logic [7:0] crc_b;

    logic [15:0] ch_a = 16'h0000;
    logic [11:0] ch_b = 12'h000;
    logic        stuck_a = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(16)) dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
        .ccff_head(head_a), .ccff_tail(tail_a), .ccff_shift_en(shift_a),
        .busy(busy_a), .done(done_a), .crc_err(err_a), .crc_value(crc_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(12)) dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .ccff_shift_en(shift_b),
        .busy(busy_b), .done(done_b), .crc_err(err_b), .crc_value(crc_b)
    );

    assign tail_a = ch_a[15];
    assign tail_b = ch_b[11];

    // Behavioural chains; FF 5 of chain A can be held at 0
    always @(posedge prog_clk) begin
        if (shift_a) ch_a <= {ch_a[14:0], head_a} & (stuck_a ? 16'hFFDF : 16'hFFFF);
        if (shift_b) ch_b <= {ch_b[10:0], head_b};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [31:0] bits, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[7] ^ bits[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic run_load(
        input  bit         use_b,
        input  int         len,
        input  int         nb,
        input  logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
        input  int         gap_lo, input int gap_len,
        input  int         sp1, input int sp2, input int rst_cyc,
        output int         done_cyc, output int n_acc, output int n_shift, output int n_stall,
        output logic       err, output logic [7:0] crc, output logic [15:0] snap
    );
        logic [7:0] bytes [3];
        int         idx;
        bit         snapped;
        logic       rdy, sh, bsy, dn, hd, eo;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        idx = 0; done_cyc = -1; n_acc = 0; n_shift = 0; n_stall = 0;
        err = 1'bx; crc = 8'hxx; snap = 16'h0000; snapped = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge prog_clk);
            start_a    = !use_b && (cyc == 0 || cyc == sp1 || cyc == sp2);
            start_b    =  use_b && (cyc == 0 || cyc == sp1 || cyc == sp2);
            prog_reset = (rst_cyc > 0) && (cyc == rst_cyc);
            s_valid    = (idx < nb) && !(cyc >= gap_lo && cyc < gap_lo + gap_len);
            s_data     = (idx < nb) ? bytes[idx] : 8'h00;
            #1;
            rdy = use_b ? s_ready_b : s_ready_a;
            sh  = use_b ? shift_b   : shift_a;
            bsy = use_b ? busy_b    : busy_a;
            dn  = use_b ? done_b    : done_a;
            hd  = use_b ? head_b    : head_a;
            eo  = use_b ? err_b     : err_a;
            if (cyc == 0) check("ready_in_idle", rdy, 1'b0);
            if (cyc == 1) begin
                check("busy_after_start", bsy, 1'b1);
                check("ready_after_start", rdy, 1'b1);
                check("err_cleared_by_start", eo, 1'b0);
            end
            if (cyc == 2) begin
                check("first_shift_en", sh, 1'b1);
                check("first_head_bit", hd, b0[0]);
            end
            if (rst_cyc > 0 && cyc == rst_cyc) check("shift_drop_in_reset", sh, 1'b0);
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                check("busy_after_reset", bsy, 1'b0);
                check("shift_after_reset", sh, 1'b0);
                check("ready_after_reset", rdy, 1'b0);
            end
            if (!snapped && n_shift == len) begin
                snap    = use_b ? {4'h0, ch_b} : ch_a;
                snapped = 1'b1;
            end
            if (rdy && s_valid) begin idx++; n_acc++; end
            if (sh) n_shift++;
            if (bsy && !sh) n_stall++;
            if (dn && done_cyc < 0) begin
                done_cyc = cyc;
                err      = eo;
                crc      = use_b ? crc_b : crc_a;
                check("busy_low_in_finish", bsy, 1'b0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            if (rst_cyc > 0 && cyc == rst_cyc + 30) break;
        end
        @(negedge prog_clk);
        start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0; prog_reset = 1'b0;
    endtask

    int          dc, na, ns, nst;
    logic        e;
    logic [7:0]  c;
    logic [15:0] sn;
    logic [7:0]  crc16, crc12;

    initial begin
        crc16 = crc_ref(32'h0000_3CA5, 16);
        crc12 = crc_ref(32'h0000_0FFF, 12);
        prog_reset = 1'b1; start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        check("rst_s_ready", s_ready_a, 1'b0);
        check("rst_head", head_a, 1'b0);
        check("rst_shift_en", shift_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_crc_err", err_a, 1'b0);
        check("rst_crc_value", crc_a, 8'h00);
        check("rst_busy_b", busy_b, 1'b0);
        prog_reset = 1'b0;

        // Always-valid 16-bit load
        run_load(1'b0, 16, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, -1, -1, 0, dc, na, ns, nst, e, c, sn);
        check("s1_done_cycle", dc, 34);
        check("s1_crc_err", e, 1'b0);
        check("s1_crc_value", c, crc16);
        check("s1_bytes_accepted", na, 2);
        check("s1_shift_cycles", ns, 32);
        check("s1_stall_cycles", nst, 1);
        check("s1_chain_after_load", sn, 16'hA53C);
        check("s1_chain_after_verify", ch_a, 16'hA53C);

        // 12-bit chain, upper nibble of second byte dropped, third byte never taken
        run_load(1'b1, 12, 3, 8'hFF, 8'h0F, 8'hEE, 0, 0, -1, -1, 0, dc, na, ns, nst, e, c, sn);
        check("s2_done_cycle", dc, 26);
        check("s2_bytes_accepted", na, 2);
        check("s2_shift_cycles", ns, 24);
        check("s2_crc_err", e, 1'b0);
        check("s2_crc_value", c, crc12);
        check("s2_chain_after_load", sn, 16'h0FFF);
        check("s2_chain_after_verify", ch_b, 12'hFFF);

        // Source stalls for 5 cycles at the byte boundary
        ch_a = 16'h0000;
        run_load(1'b0, 16, 2, 8'hA5, 8'h3C, 8'h00, 9, 5, -1, -1, 0, dc, na, ns, nst, e, c, sn);
        check("s3_done_cycle", dc, 39);
        check("s3_stall_cycles", nst, 6);
        check("s3_shift_cycles", ns, 32);
        check("s3_crc_err", e, 1'b0);
        check("s3_crc_value", c, crc16);
        check("s3_chain_after_load", sn, 16'hA53C);
        check("s3_chain_after_verify", ch_a, 16'hA53C);

        // Stuck-at-0 flip-flop inside chain A
        stuck_a = 1'b1;
        run_load(1'b0, 16, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, -1, -1, 0, dc, na, ns, nst, e, c, sn);
        check("s4_done_cycle", dc, 34);
        check("s4_crc_err", e, 1'b1);
        check("s4_crc_value", c, crc16);
        stuck_a = 1'b0;

        // Reset after 7 load bits; crc_err from the stuck run is cleared by this start
        run_load(1'b0, 16, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, -1, -1, 9, dc, na, ns, nst, e, c, sn);
        check("s5_no_done", dc, -1);

        // Full load after reset, with start pulsed during LOAD and VERIFY
        run_load(1'b0, 16, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, 5, 25, 0, dc, na, ns, nst, e, c, sn);
        check("s6_done_cycle", dc, 34);
        check("s6_shift_cycles", ns, 32);
        check("s6_crc_err", e, 1'b0);
        check("s6_crc_value", c, crc16);
        check("s6_chain_after_verify", ch_a, 16'hA53C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the fabric's switch and connection blocks. It takes the bitstream as a byte stream with a valid/ready handshake, serialises it onto `ccff_head` of the first configuration flip-flop, and drives a chain shift enable for the external clock gate. After loading, it runs a non-destructive verify pass: the chain is rotated (`ccff_tail` fed back into `ccff_head`), and a CRC-8 of the bits returning from `ccff_tail` is compared against the CRC-8 of the bits loaded.

## Interface
- `CHAIN_LEN`, default 256: total configuration flip-flops in the chain; must be ≥ 1.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `prog_clk` in 1: programming clock; the only clock.
- `prog_reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE.
- `s_data` in 8: bitstream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: byte accepted when `s_valid && s_ready`.
- `ccff_head` out 1: serial data into the chain head.
- `ccff_tail` in 1: serial data out of the chain tail.
- `ccff_shift_en` out 1: chain shifts on this `prog_clk` edge; drives the external ICG.
- `busy` out 1: high in LOAD and VERIFY.
- `done` out 1: one-cycle pulse at the end of VERIFY.
- `crc_err` out 1: verify mismatch; held until the next accepted `start`.
- `crc_value` out 8: CRC-8 of the loaded bits; held until the next accepted `start`.

## Operation
- States: IDLE, LOAD, VERIFY, FINISH.
  - IDLE → LOAD on `start`. Clears `bit_cnt`, the byte buffer, `crc_load`, `crc_vfy` and `crc_err`.
  - LOAD → VERIFY when `bit_cnt` reaches `CHAIN_LEN`.
  - VERIFY → FINISH after `CHAIN_LEN` rotate cycles.
  - FINISH → IDLE after one cycle. `done`=1 in FINISH.
- Byte buffer: 8-bit shift register plus a 4-bit count of remaining bits. Bits go out LSB first; bytes are consumed in arrival order.
- `s_ready` = LOAD && `bytes_needed` > 0 && (`buf_cnt`==0 || (`buf_cnt`==1 && `ccff_shift_en`)).
  - `bytes_needed` = ceil((`CHAIN_LEN` − bits already accepted into the buffer) / 8).
  - This allows back-to-back bytes at one bit per cycle with no bubble.
- LOAD shift condition: `ccff_shift_en` = (`buf_cnt` > 0) && (`bit_cnt` < `CHAIN_LEN`).
  - `ccff_head` = `buf[0]`.
  - Each shift: `bit_cnt`++, the buffer shifts right, and `crc_load` updates with the bit.
  - An empty buffer stalls: `ccff_shift_en`=0 and the chain holds.
- Partial final byte: when `CHAIN_LEN` is not a multiple of 8, the upper bits of the last byte are discarded. The buffer is cleared on the transition to VERIFY.
- VERIFY:
  - `ccff_shift_en`=1 every cycle and `ccff_head` = `ccff_tail` (combinational).
  - `crc_vfy` updates with `ccff_tail` each cycle.
  - After `CHAIN_LEN` cycles, the chain holds its original contents.
- CRC-8: polynomial 0x07, init 0x00, bit-serial update.
  - `fb = crc[7] ^ bit`
  - `crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00)`
- On entry to FINISH: `crc_err` = (`crc_vfy` != `crc_load`) and `crc_value` = `crc_load`.
- `start` while `busy` or in FINISH: ignored.
- `s_valid` outside LOAD: ignored; `s_ready`=0.

## Timing
- Reset values:
  - state IDLE.
  - `s_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `crc_err` = 0.
  - `crc_value` = 0x00.
- Reset mid-operation returns to IDLE on the next edge. `ccff_shift_en` drops the same cycle. Chain contents are undefined and no `done` is issued.
- `start` at edge t: `busy`=1 and `s_ready`=1 from cycle t+1.
- First byte accepted at edge t+k: `ccff_shift_en`=1 in cycle t+k+1 with `ccff_head` = `s_data[0]`.
- Sustained load: 1 bit per cycle. `ccff_shift_en` stays high across byte boundaries if the next byte is valid at the boundary.
- Total time with an always-valid source: 1 (first byte) + `CHAIN_LEN` (load) + `CHAIN_LEN` (verify) + 1 (FINISH) cycles after `start`.
- `done`, `crc_err` and `crc_value` are valid in the same cycle. `busy` is 0 in the FINISH cycle.

## Test plan
- `CHAIN_LEN`=16, bytes 0xA5, 0x3C always valid, behavioural 16-FF chain:
  - chain after load = bits LSB first of 0xA5 then 0x3C;
  - `done` at cycle 34 after `start`, `crc_err`=0;
  - `crc_value` = reference CRC-8 of the 16 bits;
  - chain unchanged after verify.
- `CHAIN_LEN`=12, bytes 0xFF, 0x0F:
  - exactly 2 bytes accepted;
  - 12 shifts, upper nibble discarded;
  - `crc_err`=0.
- `CHAIN_LEN`=16, `s_valid` dropped for 5 cycles mid second byte:
  - `ccff_shift_en` low for exactly those stall cycles;
  - final chain contents and CRC identical to the first scenario.
- Stuck-at-0 injected on one chain FF:
  - `crc_err`=1 with `done`;
  - `crc_err` clears on the next `start`.
- `prog_reset` asserted at load bit 7:
  - next cycle state IDLE, `ccff_shift_en`=0, `busy`=0, no `done`;
  - a subsequent full load passes.
- `start` pulsed during LOAD and VERIFY: no restart and `bit_cnt` unaffected.
